switch_debounce_sync: RTL and testbench

- Conditions raw board switch/push-button inputs before they drive the combinational signal-manipulation logic.
- Each channel is synchronised into the clock domain, debounced by a per-channel stability counter, and presented as a clean level with single-cycle rise/fall pulses.
- Default 3 channels map directly onto the {aa, bb, cc} inputs of the downstream logic block.

---
 rtl/switch_debounce_sync.sv | 96 +++++++++
 tb/tb_switch_debounce_sync.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_sync.sv
// switch_debounce_sync
//   Per-channel two-flop synchroniser, stability-counter debouncer, and
//   registered rise/fall pulse generator for raw switch / push-button inputs.
//   Optional build macro: DEBOUNCE_ACTIVE_LOW_EN -- when defined, raw_in is
//   inverted before the synchroniser so active-low buttons read as 1 when
//   pressed. Reset values are identical in both builds.
//   Interface note: there is no valid/ready handshake here; clean_out is a
//   level, rise/fall are single-cycle pulses aligned with the clean_out edge,
//   and busy is a registered "something is still settling" flag.
module switch_debounce_sync #(
  parameter int N_CH          = 3,
  parameter int STABLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_CH-1:0]  raw_cond;
  logic [N_CH-1:0]  sync1_q, sync1_d;
  logic [N_CH-1:0]  sync2_q, sync2_d;
  logic [N_CH-1:0]  clean_q, clean_d;
  logic [N_CH-1:0]  rise_q, rise_d;
  logic [N_CH-1:0]  fall_q, fall_d;
  logic             busy_q, busy_d;
  logic [N_CH-1:0]  diff;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

`ifdef DEBOUNCE_ACTIVE_LOW_EN
  // Active-low buttons: a pressed (0) input becomes a logical 1.
  assign raw_cond = ~raw_in;
`else
  // Active-high switches: used as-is.
  assign raw_cond = raw_in;
`endif

  // Next-state: synchroniser shift, per-channel stability count and pulses.
  always_comb begin
    sync1_d = raw_cond;
    sync2_d = sync1_q;
    diff    = sync2_q ^ clean_q;
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    busy_d  = |diff;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (diff[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          // Input has differed long enough: commit it and pulse once.
          clean_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign clean_out = clean_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_switch_debounce_sync.sv
// tb_switch_debounce_sync
//   Directed stimulus for switch_debounce_sync (default N_CH=3,
//   STABLE_CYCLES=4). The driver pushes the expected clean_out edge
//   (edge number, level, rise, fall) into exp_q; the monitor checks every
//   cycle, popping an entry when its edge number is reached.
module tb_switch_debounce_sync;

  localparam int LAT = 5;  // sampling edge k -> clean_out change at k+5

  logic       clk;
  logic       reset;
  logic [2:0] raw_in;
  logic [2:0] clean_out, rise, fall;
  logic       busy;

  int         cyc      = 0;
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         checking = 0;
  logic [2:0] cur_lvl  = '0;  // logical level most recently driven
  logic [2:0] exp_clean = '0; // clean_out the monitor currently expects
  logic [24:0] exp_q[$];      // {edge[15:0], clean, rise, fall}

  switch_debounce_sync dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy)
  );

  // Clock / edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b expected %b", nm, cyc, act, exp_v);
    end
  endtask

  // Apply a logical level to the pins (inverted for the active-low build).
  task automatic set_raw(input logic [2:0] lvl);
`ifdef DEBOUNCE_ACTIVE_LOW_EN
    raw_in = ~lvl;
`else
    raw_in = lvl;
`endif
  endtask

  // Drive a held level and record the clean_out edge it must produce.
  task automatic drive(input logic [2:0] lvl);
    set_raw(lvl);
    if (lvl != cur_lvl)
      exp_q.push_back({16'(cyc + 1 + LAT), lvl, lvl & ~cur_lvl, cur_lvl & ~lvl});
    cur_lvl = lvl;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: runs #1 after each rising edge.
  initial begin
    logic [24:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (checking) begin
        if (exp_q.size() > 0 && exp_q[0][24:9] == cyc[15:0]) begin
          e = exp_q.pop_front();
          exp_clean = e[8:6];
          check("rise_pulse", rise, e[5:3]);
          check("fall_pulse", fall, e[2:0]);
        end else begin
          check("rise_idle", rise, 3'b000);
          check("fall_idle", fall, 3'b000);
        end
        check("clean_out", clean_out, exp_clean);
      end
    end
  end

  // Driver
  initial begin
    int k;
    logic [7:0] xor_tab;
    xor_tab = 8'b0011_1100;
    reset = 1'b1;
    set_raw(3'b000);
    @(posedge clk);
    @(negedge clk);
    // Reset state
    check("reset_clean", clean_out, 3'b000);
    check("reset_rise", rise, 3'b000);
    check("reset_fall", fall, 3'b000);
    check("reset_busy", {2'b00, busy}, 3'b000);
    reset = 1'b0;
    checking = 1'b1;

    // Idle 20 cycles at 000
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy", {2'b00, busy}, 3'b000);
    end

    // 000 -> 101 with busy window k+2..k+5
    k = cyc + 1;
    drive(3'b101);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy_window", {2'b00, busy}, {2'b00, (cyc >= k + 2 && cyc <= k + 5)});
    end
    drive(3'b000);
    wait_cycles(10);

    // Glitch of 3 cycles on bit 1: rejected, no event expected
    set_raw(3'b010);
    wait_cycles(3);
    set_raw(3'b000);
    wait_cycles(10);
    check("glitch_busy", {2'b00, busy}, 3'b000);

    // Sweep 0..7 with downstream XOR of clean_out[2]^clean_out[1]
    for (int v = 0; v < 8; v++) begin
      drive(3'(v));
      wait_cycles(10);
      check("sweep_xor", {2'b00, clean_out[2] ^ clean_out[1]}, {2'b00, xor_tab[v]});
    end
    drive(3'b000);
    wait_cycles(10);

    // Reset while bit0 count is at 2
    drive(3'b001);           // sampled at edge k
    wait_cycles(3);          // edges k..k+2 done; count becomes 2 at k+3
    @(negedge clk);          // after edge k+3
    reset = 1'b1;
    exp_q.delete();
    exp_clean = 3'b000;
    cur_lvl = 3'b000;
    @(negedge clk);
    check("midreset_clean", clean_out, 3'b000);
    check("midreset_busy", {2'b00, busy}, 3'b000);
    reset = 1'b0;
    drive(3'b001);           // still held; first post-reset edge samples it
    wait_cycles(10);
    drive(3'b000);
    wait_cycles(10);

`ifdef DEBOUNCE_ACTIVE_LOW_EN
    // Active-low: idle pins at 111, press bit0 (pins 110)
    check("al_idle_clean", clean_out, 3'b000);
    drive(3'b001);
    check("al_pins", raw_in, 3'b110);
    wait_cycles(10);
`endif

    // Every expected edge must have been consumed
    check("queue_drained", 3'(exp_q.size() > 7 ? 7 : exp_q.size()), 3'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
